// File: rtl/fma_seq.sv
// Control sequencer for the shared FMA mantissa datapath: four partial products through mul0,
// one alignment load, one add0 accumulation, result held until the consumer takes it.
module fma_seq #(
  parameter int NPP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_sub,
  input  logic [23:0] req_sft,
  output logic        mul_en,
  output logic [1:0]  mul_sel,
  output logic        pp_wr,
  output logic [1:0]  pp_idx,
  output logic        aln_en,
  output logic [5:0]  aln_sft0,
  output logic [5:0]  aln_sft1,
  output logic [5:0]  aln_sft2,
  output logic [5:0]  aln_sft3,
  output logic        add_en,
  output logic        add_sub,
  output logic [1:0]  add_cin,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy
);

  localparam logic [1:0] LAST_PP = 2'(NPP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    DRAIN = 3'd2,
    ADD   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        sub_q, sub_d;
  logic [23:0] sft_q, sft_d;
  logic        pp_wr_q;
  logic [1:0]  pp_idx_q;
  logic        accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      sub_q   <= 1'b0;
      sft_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      sft_q   <= sft_d;
    end
  end

  // mul0 output is registered, so the capture strobe trails the multiply by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pp_wr_q  <= 1'b0;
      pp_idx_q <= 2'd0;
    end else begin
      pp_wr_q  <= (state_q == MUL);
      pp_idx_q <= (state_q == MUL) ? cnt_q : 2'd0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
    sft_d     = sft_q;
    req_ready = 1'b0;

    case (state_q)
      IDLE:    req_ready = ~reset;
      DONE:    req_ready = ~reset & res_ready;
      default: req_ready = 1'b0;
    endcase

    accept = req_valid & req_ready;

    case (state_q)
      IDLE: begin
        if (accept) state_d = MUL;
      end
      MUL: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_PP) state_d = DRAIN;
      end
      DRAIN:   state_d = ADD;
      ADD:     state_d = DONE;
      DONE: begin
        if (res_ready) state_d = accept ? MUL : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      sub_d = req_sub;
      sft_d = req_sft;
      cnt_d = 2'd0;
    end
  end

  assign mul_en    = (state_q == MUL);
  assign mul_sel   = (state_q == MUL) ? cnt_q : 2'd0;
  assign aln_en    = (state_q == MUL) && (cnt_q == 2'd0);
  assign pp_wr     = pp_wr_q;
  assign pp_idx    = pp_idx_q;
  assign add_en    = (state_q == ADD);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  // Two inverted operands on a subtract each need their own +1.
  assign add_sub   = sub_q;
  assign add_cin   = sub_q ? 2'b10 : 2'b00;

  assign aln_sft0  = sft_q[5:0];
  assign aln_sft1  = sft_q[11:6];
  assign aln_sft2  = sft_q[17:12];
  assign aln_sft3  = sft_q[23:18];

endmodule

// File: tb/tb_fma_seq.sv
// Scoreboard bench for fma_seq: directed requests push timed expectations, a negedge monitor pops them.
module tb_fma_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_sub;
  logic [23:0] req_sft;
  logic        mul_en, pp_wr, aln_en, add_en, add_sub, res_valid, res_ready, busy;
  logic [1:0]  mul_sel, pp_idx, add_cin;
  logic [5:0]  aln_sft0, aln_sft1, aln_sft2, aln_sft3;

  fma_seq #(.NPP(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub), .req_sft(req_sft),
    .mul_en(mul_en), .mul_sel(mul_sel), .pp_wr(pp_wr), .pp_idx(pp_idx),
    .aln_en(aln_en), .aln_sft0(aln_sft0), .aln_sft1(aln_sft1), .aln_sft2(aln_sft2), .aln_sft3(aln_sft3),
    .add_en(add_en), .add_sub(add_sub), .add_cin(add_cin),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [1:0] sel; logic aln; logic [23:0] sft; } mul_exp_t;
  typedef struct { int c; logic [1:0] idx; } pp_exp_t;
  typedef struct { int c; logic sub; logic [1:0] cin; } add_exp_t;

  mul_exp_t mq[$];
  pp_exp_t  pq[$];
  add_exp_t aq[$];
  int       rq[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: output with no expectation queued (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [63:0] outs();
    return {27'd0, mul_en, pp_wr, aln_en, add_en, res_valid, busy, pp_idx, mul_sel, add_cin,
            aln_sft3, aln_sft2, aln_sft1, aln_sft0, add_sub};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  // Drive a request in the current cycle; it must be accepted here.
  task automatic do_accept(input logic sub, input logic [23:0] sft, input logic [1:0] cin);
    mul_exp_t m;
    pp_exp_t  p;
    add_exp_t a;
    req_valid = 1'b1;
    req_sub   = sub;
    req_sft   = sft;
    #1;
    chk("accept_ready", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      m.c = cyc + 1 + i; m.sel = 2'(i); m.aln = (i == 0); m.sft = sft;
      mq.push_back(m);
      p.c = cyc + 2 + i; p.idx = 2'(i);
      pq.push_back(p);
    end
    a.c = cyc + 6; a.sub = sub; a.cin = cin;
    aq.push_back(a);
    rq.push_back(cyc + 7);
  endtask

  mul_exp_t me;
  pp_exp_t  pe;
  add_exp_t ae;
  int       re;
  logic     res_prev = 1'b0;

  always @(negedge clk) begin
    if (mul_en) begin
      if (mq.size() == 0) unexpected("mul_en");
      else begin
        me = mq.pop_front();
        chk("mul_cycle", 64'(cyc), 64'(me.c));
        chk("mul_sel", mul_sel, me.sel);
        chk("aln_en", aln_en, me.aln);
        chk("aln_sft", {aln_sft3, aln_sft2, aln_sft1, aln_sft0}, me.sft);
      end
    end else if (aln_en) unexpected("aln_en");
    if (pp_wr) begin
      if (pq.size() == 0) unexpected("pp_wr");
      else begin
        pe = pq.pop_front();
        chk("pp_cycle", 64'(cyc), 64'(pe.c));
        chk("pp_idx", pp_idx, pe.idx);
      end
    end
    if (add_en) begin
      chk("add_mul_excl", mul_en, 1'b0);
      if (aq.size() == 0) unexpected("add_en");
      else begin
        ae = aq.pop_front();
        chk("add_cycle", 64'(cyc), 64'(ae.c));
        chk("add_sub", add_sub, ae.sub);
        chk("add_cin", add_cin, ae.cin);
      end
    end
    if (res_valid && !res_prev) begin
      if (rq.size() == 0) unexpected("res_valid");
      else begin
        re = rq.pop_front();
        chk("res_cycle", 64'(cyc), 64'(re));
      end
    end
    res_prev = res_valid;
  end

  int a;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_sub = 1'b0; req_sft = 24'd0; res_ready = 1'b1;
    repeat (2) tick();
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_outs", outs(), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1'b1);

    // Single add op
    tick(); a = cyc;
    do_accept(1'b0, 24'h000000, 2'b00);
    tick(); req_valid = 1'b0;
    tick_to(a + 8);
    chk("t1_idle", {busy, res_valid}, 2'b00);

    // Subtract op with odd shift pattern
    tick(); a = cyc;
    do_accept(1'b1, 24'hFC1041, 2'b10);
    tick(); req_valid = 1'b0; #1;
    chk("t2_aln_en_c1", aln_en, 1'b1);
    chk("t2_sft0", aln_sft0, 6'd1);
    chk("t2_sft1", aln_sft1, 6'd1);
    chk("t2_sft2", aln_sft2, 6'd1);
    chk("t2_sft3", aln_sft3, 6'd63);
    tick_to(a + 2);
    chk("t2_aln_en_c2", aln_en, 1'b0);
    tick_to(a + 6);
    chk("t2_add_sub", add_sub, 1'b1);
    chk("t2_add_cin", add_cin, 2'b10);
    tick_to(a + 8);

    // Result backpressure, with a competing request that must be ignored
    tick(); a = cyc;
    do_accept(1'b0, 24'h123456, 2'b00);
    tick(); req_valid = 1'b0; res_ready = 1'b0;
    tick_to(a + 7);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_sft = 24'hABCDEF; #1;
      chk("bp_res_valid", res_valid, 1'b1);
      chk("bp_req_ready", req_ready, 1'b0);
      tick();
    end
    req_valid = 1'b0; res_ready = 1'b1; #1;
    chk("bp_release_ready", req_ready, 1'b1);
    tick();
    chk("bp_idle", {busy, res_valid}, 2'b00);

    // Back-to-back
    tick(); a = cyc;
    do_accept(1'b0, 24'h0A0B0C, 2'b00);
    tick(); req_sub = 1'b1; req_sft = 24'h3F2E1D;
    tick_to(a + 7);
    do_accept(1'b1, 24'h3F2E1D, 2'b10);
    tick(); req_valid = 1'b0; #1;
    chk("b2b_add_sub_c8", add_sub, 1'b1);
    tick_to(a + 15);
    chk("b2b_idle", busy, 1'b0);

    // Requests while busy are ignored
    tick(); a = cyc;
    do_accept(1'b0, 24'h555555, 2'b00);
    tick(); req_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      tick_to(a + c);
      req_valid = 1'b1; req_sub = 1'b1; req_sft = 24'hAAAAAA; #1;
      chk("busy_no_ready", req_ready, 1'b0);
    end
    tick_to(a + 6); req_valid = 1'b0; #1;
    chk("busy_sft_held", {aln_sft3, aln_sft2, aln_sft1, aln_sft0}, 24'h555555);
    chk("busy_sub_held", add_sub, 1'b0);
    tick_to(a + 8);

    // Reset mid-operation, then a fresh op right after
    tick(); a = cyc;
    do_accept(1'b1, 24'h7E9F31, 2'b10);
    tick(); req_valid = 1'b0;
    tick_to(a + 4);
    reset = 1'b1;
    tick();
    mq.delete(); pq.delete(); aq.delete(); rq.delete();
    reset = 1'b0; #1;
    chk("midrst_outs", outs(), 64'd0);
    do_accept(1'b0, 24'h102030, 2'b00);
    tick(); req_valid = 1'b0;
    tick_to(a + 13);
    chk("midrst_idle", busy, 1'b0);

    repeat (3) tick();
    chk("left_mul", 64'(mq.size()), 64'd0);
    chk("left_pp", 64'(pq.size()), 64'd0);
    chk("left_add", 64'(aq.size()), 64'd0);
    chk("left_res", 64'(rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
